activation_stack_pipelined: RTL and testbench

//  Activation store for the backprop datapath. It holds the input activations plus the activations of

---
 rtl/activation_stack_pipelined.sv | 114 +++++++++++
 tb/tb_activation_stack_pipelined.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/activation_stack_pipelined.sv
// Activation stack: word-addressed memory that returns READ_SPAN consecutive words per request,
// through a one-cycle stage register and a 3-entry output FIFO, with write-through forwarding.
module activation_stack_pipelined #(
  parameter int NEURON_NUM       = 6,
  parameter int ACTIVATION_WIDTH = 8,
  parameter int ADDR_WIDTH       = 10,
  parameter int READ_SPAN        = 2,
  localparam int STACK_WIDTH     = NEURON_NUM * ACTIVATION_WIDTH,
  localparam int BUNDLE_WIDTH    = READ_SPAN * STACK_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STACK_WIDTH-1:0]  wr_data,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  output logic [BUNDLE_WIDTH-1:0] out_data,
  output logic                    out_oob,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] SPAN_M1  = (ADDR_WIDTH + 1)'(READ_SPAN - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_M1 = (ADDR_WIDTH + 1)'(DEPTH - 1);

  logic [STACK_WIDTH-1:0] mem [DEPTH];

  logic                    inflight_q, inflight_d;
  logic [BUNDLE_WIDTH-1:0] stage_data_q, stage_data_d;
  logic                    stage_oob_q, stage_oob_d;
  logic [BUNDLE_WIDTH-1:0] fifo_data_q [3];
  logic [BUNDLE_WIDTH-1:0] fifo_data_d [3];
  logic [2:0]              fifo_oob_q, fifo_oob_d;
  logic [1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, count_q, count_d;

  logic                    wr_fire, rd_fire, push, pop, rd_oob;
  logic [BUNDLE_WIDTH-1:0] rd_bundle;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign wr_ready  = !rst;
  // Occupancy counts the bundle in the stage register too, so the FIFO can never overflow.
  assign rd_ready  = !rst && (({1'b0, count_q} + {2'b0, inflight_q}) < 3'd3);
  assign wr_fire   = wr_valid && wr_ready;
  assign rd_fire   = rd_valid && rd_ready;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_oob   = out_valid ? fifo_oob_q[rd_ptr_q] : 1'b0;
  assign push      = inflight_q;
  assign pop       = out_valid && out_ready;
  assign rd_oob    = ({1'b0, rd_addr} + SPAN_M1) > DEPTH_M1;

  generate
    for (genvar gi = 0; gi < READ_SPAN; gi++) begin : g_word
      logic [ADDR_WIDTH-1:0] word_addr;
      assign word_addr = rd_addr + ADDR_WIDTH'(gi);
      // A same-edge write to this word wins over the stale memory contents.
      assign rd_bundle[gi*STACK_WIDTH +: STACK_WIDTH] =
          (wr_fire && (wr_addr == word_addr)) ? wr_data : mem[word_addr];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    inflight_d   = rd_fire;
    stage_data_d = stage_data_q;
    stage_oob_d  = stage_oob_q;
    fifo_data_d  = fifo_data_q;
    fifo_oob_d   = fifo_oob_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q + {1'b0, push} - {1'b0, pop};
    if (rd_fire) begin
      stage_data_d = rd_bundle;
      stage_oob_d  = rd_oob;
    end
    if (push) begin
      fifo_data_d[wr_ptr_q] = stage_data_q;
      fifo_oob_d[wr_ptr_q]  = stage_oob_q;
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q   <= 1'b0;
      stage_data_q <= '0;
      stage_oob_q  <= 1'b0;
      fifo_data_q  <= '{default: '0};
      fifo_oob_q   <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      inflight_q   <= inflight_d;
      stage_data_q <= stage_data_d;
      stage_oob_q  <= stage_oob_d;
      fifo_data_q  <= fifo_data_d;
      fifo_oob_q   <= fifo_oob_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end
endmodule

// File: tb/tb_activation_stack_pipelined.sv
// Randomized and directed bench for activation_stack_pipelined against a transaction-level model:
// a word array plus a queue of expected bundles tagged with the edge at which each was accepted.
module tb_activation_stack_pipelined;
  localparam int NN = 6, AW_ = 8, AW = 10, SPAN = 2;
  localparam int SW = NN * AW_, BW = SPAN * SW, DEPTH = 2 ** AW;

  logic          clk = 1'b0, rst = 1'b1;
  logic [SW-1:0] wr_data = '0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic          wr_valid = 1'b0, rd_valid = 1'b0, out_ready = 1'b0;
  logic          wr_ready, rd_ready, out_oob, out_valid;
  logic [BW-1:0] out_data;

  activation_stack_pipelined #(.NEURON_NUM(NN), .ACTIVATION_WIDTH(AW_), .ADDR_WIDTH(AW),
                               .READ_SPAN(SPAN)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_addr(wr_addr), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .out_data(out_data), .out_oob(out_oob), .out_valid(out_valid), .out_ready(out_ready));

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] data;
    logic          oob;
    int            edge_idx;
  } bundle_t;

  logic [SW-1:0] mem_m [DEPTH];
  bundle_t       q[$];
  int            edge_cnt = 0;
  int            compared = 0, mismatched = 0;
  bit            last_rf;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, then advance the model past the rising edge.
  task automatic cycle(input bit wv, input int wa, input logic [SW-1:0] wd,
                       input bit rv, input int ra, input bit ordy);
    bit exp_rdy, exp_v, wf, rf, pf;
    bundle_t b;
    wr_valid = wv; wr_addr = AW'(wa); wr_data = wd;
    rd_valid = rv; rd_addr = AW'(ra); out_ready = ordy;
    @(negedge clk);
    exp_rdy = !rst && (q.size() < 3);
    exp_v   = (q.size() > 0) && (edge_cnt >= q[0].edge_idx + 1);
    check("wr_ready", wr_ready, !rst);
    check("rd_ready", rd_ready, exp_rdy);
    check("out_valid", out_valid, exp_v);
    if (exp_v) begin
      check("out_data", out_data, q[0].data);
      check("out_oob", out_oob, q[0].oob);
    end
    wf = wv && !rst;
    rf = rv && exp_rdy;
    pf = exp_v && ordy;
    @(posedge clk);
    edge_cnt++;
    if (wf) mem_m[wa % DEPTH] = wd;
    if (pf) void'(q.pop_front());
    if (rf) begin
      for (int i = 0; i < SPAN; i++) b.data[i*SW +: SW] = mem_m[(ra + i) % DEPTH];
      b.oob      = (ra + SPAN - 1) > (DEPTH - 1);
      b.edge_idx = edge_cnt;
      q.push_back(b);
    end
    last_rf = rf;
    #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, 0, ordy);
  endtask

  initial begin
    int idx, n, ra, wa;
    // Reset with every request asserted: nothing may be accepted or presented.
    cycle(1, 1, {SW{1'b1}}, 1, 1, 1);
    cycle(1, 2, {SW{1'b1}}, 1, 2, 1);
    check("rst_oob", out_oob, 0);
    check("rst_data", out_data, 0);
    rst = 1'b0;
    idle(1, 1);

    for (int a = 0; a < DEPTH; a++) cycle(1, a, SW'({$urandom, $urandom}), 0, 0, 1);

    // Basic write then read of the layer pair 3/4.
    cycle(1, 3, {NN{8'h0A}}, 0, 0, 1);
    cycle(1, 4, {NN{8'h0B}}, 0, 0, 1);
    cycle(0, 0, '0, 1, 3, 1);
    idle(1, 1);
    check("pair_valid", out_valid, 1);
    check("pair_data", out_data, {{NN{8'h0B}}, {NN{8'h0A}}});
    idle(3, 1);

    // Back-pressure: only three requests fit while the consumer is stalled.
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, '0, idx < 4, idx, 0);
      if (last_rf) idx++;
    end
    check("bp_accepts", idx, 3);
    for (int i = 0; i < 20 && idx < 4; i++) begin
      cycle(0, 0, '0, 1, idx, 1);
      if (last_rf) idx++;
    end
    check("bp_done", idx, 4);
    idle(4, 1);

    // Full throughput with a free-running consumer.
    n = 0;
    for (int a = 0; a < 8; a++) begin
      cycle(0, 0, '0, 1, a, 1);
      if (last_rf) n++;
    end
    check("tput_accepts", n, 8);
    idle(4, 1);

    // Address wrap at the top of the stack.
    cycle(0, 0, '0, 1, DEPTH - 1, 1);
    idle(2, 1);
    cycle(0, 0, '0, 1, DEPTH - 2, 1);
    idle(3, 1);

    // Same-edge write into the upper word of a read.
    cycle(1, 5, {NN{8'h55}}, 1, 4, 1);
    idle(1, 1);
    check("fwd_hi", out_data[BW-1 -: SW], {NN{8'h55}});
    idle(3, 1);

    // Reset with two bundles queued: they must vanish at once and never reappear.
    cycle(0, 0, '0, 1, 10, 0);
    cycle(0, 0, '0, 1, 11, 0);
    idle(2, 0);
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    q.delete();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    cycle(1, 20, {SW{1'b1}}, 1, 20, 1);
    rst = 1'b0;
    idle(4, 1);

    // Randomized traffic, biased toward the wrap boundary and read/write collisions.
    for (int i = 0; i < 500; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? DEPTH - 1 - $urandom_range(0, 2)
                                       : $urandom_range(0, DEPTH - 1);
      wa = $urandom_range(0, 1) ? (ra + $urandom_range(0, SPAN)) % DEPTH
                                : $urandom_range(0, DEPTH - 1);
      cycle($urandom_range(0, 1), wa, SW'({$urandom, $urandom}),
            $urandom_range(0, 2) != 0, ra, $urandom_range(0, 3) != 0);
    end
    idle(6, 1);
    check("drain_empty", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
